fft8_unscramble_serializer: RTL

- Consumer-side companion to the 8-point pipelined FFT.
- Each cycle the FFT presents 8 parallel complex bins in bit-reversed slot order.
- This block captures whole frames into a 2-deep ping-pong frame buffer and streams them out one complex sample per beat, in natural bin order (0..7), over a valid/ready handshake.
- It sits between the FFT core and serial downstream consumers (magnitude, DMA, UART dump).

---
 rtl/fft8_unscramble_serializer.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/fft8_unscramble_serializer.sv
// fft8_unscramble_serializer
//   Accepts whole 8-bin FFT frames (slots in bit-reversed order) into a
//   two-entry ping-pong frame buffer. It then streams each frame out one
//   complex sample per beat, in natural bin order, over valid/ready.
//   Optional build macro: FFT8_UNSCRAMBLE_SCALE_EN applies an arithmetic
//   right shift by SCALE_SH to out_real/out_imag on the read path.
module fft8_unscramble_serializer #(
  parameter int DATA_W   = 32,
  parameter int SCALE_SH = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in0_real,
  input  logic [DATA_W-1:0] in1_real,
  input  logic [DATA_W-1:0] in2_real,
  input  logic [DATA_W-1:0] in3_real,
  input  logic [DATA_W-1:0] in4_real,
  input  logic [DATA_W-1:0] in5_real,
  input  logic [DATA_W-1:0] in6_real,
  input  logic [DATA_W-1:0] in7_real,
  input  logic [DATA_W-1:0] in0_imag,
  input  logic [DATA_W-1:0] in1_imag,
  input  logic [DATA_W-1:0] in2_imag,
  input  logic [DATA_W-1:0] in3_imag,
  input  logic [DATA_W-1:0] in4_imag,
  input  logic [DATA_W-1:0] in5_imag,
  input  logic [DATA_W-1:0] in6_imag,
  input  logic [DATA_W-1:0] in7_imag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_real,
  output logic [DATA_W-1:0] out_imag,
  output logic [2:0]        out_index,
  output logic              out_last
);

  localparam int N = 8;

  // Reject shift amounts that cannot be applied to a DATA_W-bit sample.
  if (SCALE_SH < 0 || SCALE_SH >= DATA_W) begin : g_bad_scale_sh
    $error("SCALE_SH must lie in 0..DATA_W-1");
  end

  // Slot k of a frame carries bin bitrev3(k), and the reverse also holds.
  function automatic logic [2:0] bitrev3(input logic [2:0] v);
    return {v[0], v[1], v[2]};
  endfunction

  // Gather the flat input ports into slot-indexed arrays.
  logic [DATA_W-1:0] in_re [N];
  logic [DATA_W-1:0] in_im [N];

  assign in_re[0] = in0_real;
  assign in_re[1] = in1_real;
  assign in_re[2] = in2_real;
  assign in_re[3] = in3_real;
  assign in_re[4] = in4_real;
  assign in_re[5] = in5_real;
  assign in_re[6] = in6_real;
  assign in_re[7] = in7_real;
  assign in_im[0] = in0_imag;
  assign in_im[1] = in1_imag;
  assign in_im[2] = in2_imag;
  assign in_im[3] = in3_imag;
  assign in_im[4] = in4_imag;
  assign in_im[5] = in5_imag;
  assign in_im[6] = in6_imag;
  assign in_im[7] = in7_imag;

  // Ping-pong frame storage, indexed [buffer][slot].
  logic [DATA_W-1:0] buf_re_q [2][N];
  logic [DATA_W-1:0] buf_im_q [2][N];

  // Pointer and occupancy state.
  logic       wr_sel_q, wr_sel_d;
  logic       rd_sel_q, rd_sel_d;
  logic [1:0] count_q,  count_d;   // frames held, 0..2
  logic [2:0] rd_idx_q, rd_idx_d;  // natural bin of the current output sample
  logic       live_q;              // low while in reset and until the first edge after it

  logic accept;
  logic beat;
  logic last_beat;

  // Handshake decode uses registered state only, so out_ready never reaches in_ready.
  assign in_ready  = live_q && (count_q < 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign accept    = in_valid && in_ready;
  assign beat      = out_valid && out_ready;
  assign last_beat = beat && (rd_idx_q == 3'd7);

  // Next-state for pointers, read index and frame count.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned (no latch).
    wr_sel_d = wr_sel_q;
    rd_sel_d = rd_sel_q;
    count_d  = count_q;
    rd_idx_d = rd_idx_q;

    if (accept) begin
      wr_sel_d = ~wr_sel_q;
    end

    if (beat) begin
      rd_idx_d = rd_idx_q + 3'd1;  // wraps 7 -> 0 naturally
    end

    if (last_beat) begin
      rd_sel_d = ~rd_sel_q;
    end

    // An accept and a final beat in the same cycle cancel out in count.
    unique case ({accept, last_beat})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Control state register; reset discards any buffered or partially sent frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      wr_sel_q <= 1'b0;
      rd_sel_q <= 1'b0;
      count_q  <= 2'd0;
      rd_idx_q <= 3'd0;
      live_q   <= 1'b0;
    end else begin
      wr_sel_q <= wr_sel_d;
      rd_sel_q <= rd_sel_d;
      count_q  <= count_d;
      rd_idx_q <= rd_idx_d;
      live_q   <= 1'b1;
    end
  end

  // Capture a whole frame into the buffer selected by wr_sel.
  // NOTE: frame storage has no reset; count_q alone decides whether its contents are meaningful.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int k = 0; k < N; k++) begin
        buf_re_q[wr_sel_q][k] <= in_re[k];
        buf_im_q[wr_sel_q][k] <= in_im[k];
      end
    end
  end

  // Read path: natural bin rd_idx lives in slot bitrev3(rd_idx).
  logic [DATA_W-1:0] raw_re, raw_im;
  logic [DATA_W-1:0] rd_re,  rd_im;

  assign raw_re = buf_re_q[rd_sel_q][bitrev3(rd_idx_q)];
  assign raw_im = buf_im_q[rd_sel_q][bitrev3(rd_idx_q)];

`ifdef FFT8_UNSCRAMBLE_SCALE_EN
  // Sign-extending shift, so results truncate toward minus infinity.
  assign rd_re = $signed(raw_re) >>> SCALE_SH;
  assign rd_im = $signed(raw_im) >>> SCALE_SH;
`else
  assign rd_re = raw_re;
  assign rd_im = raw_im;
`endif

  // Output fields read as zero whenever no sample is offered.
  assign out_real  = out_valid ? rd_re : '0;
  assign out_imag  = out_valid ? rd_im : '0;
  assign out_index = out_valid ? rd_idx_q : 3'd0;
  assign out_last  = out_valid && (rd_idx_q == 3'd7);

endmodule
